serial_add16_ctrl: RTL and testbench
====================================

SERIAL_ADD16_CTRL -- requirements
Module: serial_add16_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4, SHALL set the number of 4-bit slices per operation; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL flag that a and b carry a new operand pair.
REQ-005 in_ready  output  1  SHALL flag that the block accepts an operand pair this cycle.
REQ-006 a, b  input  W each  SHALL be the unsigned operands.
REQ-007 out_valid  output  1  SHALL flag that sum and cout hold a completed result.
REQ-008 out_ready  input  1  SHALL flag that the consumer takes the result this cycle.
REQ-009 sum  output  W  SHALL be the registered result a+b mod 2^W.
REQ-010 cout  output  1  SHALL be the registered carry out of bit W-1.

Function
REQ-011 FSM states SHALL be IDLE, ADD, HOLD.
REQ-012 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in HOLD.
REQ-013 IDLE: on in_valid=1, SHALL latch a and b, clear the carry register and the nibble counter, and enter ADD; otherwise stay in IDLE.
REQ-014 ADD: each cycle SHALL add nibble[cnt] of the latched operands plus the carry register through one shared 4-bit slice, write the 4-bit result to sum nibble cnt, update the carry register, and increment cnt.
REQ-015 ADD with cnt=NIBBLES-1 SHALL load cout from the slice carry and enter HOLD.
REQ-016 Latency: handshake at edge k SHALL give out_valid=1 after edge k+NIBBLES.
REQ-017 HOLD: sum, cout and out_valid SHALL stay stable while out_ready=0; on out_ready=1, SHALL return to IDLE; out_valid drops after that edge.
REQ-018 Input changes on a and b after acceptance SHALL NOT affect the result in progress.
REQ-019 in_valid while in ADD or HOLD SHALL be ignored; no operand is lost silently, because in_ready=0 tells the producer to hold it.
REQ-020 Throughput SHALL be at most one operation per NIBBLES+2 cycles; in_ready SHALL NOT be asserted in HOLD.
REQ-021 cnt SHALL be ceil(log2(NIBBLES)) bits wide, or 1 bit wide when NIBBLES=1, and SHALL NOT wrap within an operation.
REQ-022 sum nibbles not yet written in ADD SHALL keep their previous value; they are not observable because out_valid=0.

Reset
REQ-023 rst_n=0 SHALL, without waiting for a clock edge, force state to IDLE, cnt=0, the carry register to 0, sum=0 and cout=0; out_valid is then 0 and in_ready is 1.
REQ-024 Reset during ADD or HOLD SHALL discard the operation in progress; no out_valid SHALL follow for it.
REQ-025 Reset release SHALL leave the block in IDLE ready to accept on the first edge with in_valid=1.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE=0, ADD=1, HOLD=2, 2-bit) and the slice width constant 4.
REQ-027 The 4-bit adder slice with carry-in SHALL be one sub-module, add4_cin (inputs a[3:0], b[3:0], cin; outputs s[3:0], cout), instantiated once.
REQ-028 Nibble selection and sum write-back SHALL use cnt-indexed part-selects; no second adder instance is permitted.

Verification
REQ-029 0x0000+0x0000 -> out_valid 4 cycles after accept, sum=0x0000, cout=0.
REQ-030 0x000F+0x0001 -> sum=0x0010, cout=0; checks the carry between nibbles.
REQ-031 0xFFFF+0x0001 -> sum=0x0000, cout=1; 0xFFFF+0xFFFF -> sum=0xFFFE, cout=1.
REQ-032 out_ready held 0 for 3 cycles in HOLD -> sum, cout and out_valid unchanged; in_valid pulses during ADD and HOLD are not accepted; a and b changed after accept leave the result unchanged.
REQ-033 rst_n pulsed low mid-ADD on 0x1234+0x4321 -> outputs are 0 immediately, no out_valid follows; the next 0x1234+0x4321 gives sum=0x5555, cout=0.
REQ-034 Back-to-back with in_valid held at 1 -> accepts exactly once per NIBBLES+2 cycles when out_ready=1.

Source files
------------

// File: rtl/serial_add16_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
package serial_add16_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add16_ctrl_add4_cin.sv
// 4-bit adder slice with carry-in; the serial adder reuses one instance per nibble.
module add4_cin
    import serial_add16_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

endmodule

// File: rtl/serial_add16_ctrl.sv
// Nibble-serial unsigned adder: latches an operand pair, adds one 4-bit slice per
// cycle through a shared add4_cin, then holds sum/cout until the consumer takes them.
module serial_add16_ctrl
    import serial_add16_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SLICE_W*NIBBLES-1:0] a,
    input  logic [SLICE_W*NIBBLES-1:0] b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SLICE_W*NIBBLES-1:0] sum,
    output logic                   cout
);

    localparam int W     = SLICE_W * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] s_nib;
    logic               c_nib;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);

    assign a_nib = a_q[SLICE_W*int'(cnt) +: SLICE_W];
    assign b_nib = b_q[SLICE_W*int'(cnt) +: SLICE_W];

    add4_cin u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .s    (s_nib),
        .cout (c_nib)
    );

    // Operand latches carry no reset: they are only read after a fresh accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_q <= a;
            b_q <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt   <= '0;
                        carry <= 1'b0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum[SLICE_W*int'(cnt) +: SLICE_W] <= s_nib;
                    carry <= c_nib;
                    // cnt parks on the last nibble instead of wrapping; the next accept clears it.
                    if (cnt == LAST) begin
                        cout  <= c_nib;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add16_ctrl.sv
// Self-checking bench for serial_add16_ctrl: transaction-level reference model plus directed vectors.
module tb_serial_add16_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;

    int total = 0;
    int bad   = 0;

    serial_add16_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted pair becomes visible NIBBLES edges later and
    // stays until consumed; the block is busy from accept until consumption.
    logic         m_busy;
    int           m_age;
    logic [W:0]   m_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_res  <= '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_res  <= {1'b0, a} + {1'b0, b};
            end
        end else if (m_age < NIBBLES) begin
            m_age <= m_age + 1;
        end else if (out_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic exp_valid;
        exp_valid = m_busy && (m_age == NIBBLES);
        check("model_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, !m_busy});
        check("model_out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, exp_valid});
        if (exp_valid) check("model_result", {cout, sum}, m_res);
    end

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] es, input logic ec, input int hold);
        int lat;
        @(negedge clk);
        a = av; b = bv; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        a = ~av; b = bv ^ 16'h5A5A;
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = (lat == 1);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, NIBBLES);
        check("result", {cout, sum}, {ec, es});
        for (int i = 0; i < hold; i++) begin
            in_valid = (i == 0);
            @(negedge clk);
            check("hold_valid", {{W{1'b0}}, out_valid}, 1);
            check("hold_result", {cout, sum}, {ec, es});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("drop_valid", {{W{1'b0}}, out_valid}, 0);
        check("back_ready", {{W{1'b0}}, in_ready}, 1);
    endtask

    initial begin
        int acc_cnt;
        int last_acc;
        #2;
        check("rst_sum", {cout, sum}, 0);
        check("rst_ready", {{W{1'b0}}, in_ready}, 1);
        check("rst_valid", {{W{1'b0}}, out_valid}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        run_op(16'h0000, 16'h0000, 16'h0000, 1'b0, 0);
        run_op(16'h000F, 16'h0001, 16'h0010, 1'b0, 1);
        run_op(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0);
        run_op(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1, 3);

        // Reset pulse in the middle of an ADD phase discards the operation.
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_result", {cout, sum}, 0);
        check("midrst_valid", {{W{1'b0}}, out_valid}, 0);
        check("midrst_ready", {{W{1'b0}}, in_ready}, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_stale_valid", {{W{1'b0}}, out_valid}, 0);
        end
        out_ready = 1'b0;
        run_op(16'h1234, 16'h4321, 16'h5555, 1'b0, 0);

        // Back-to-back: in_valid and out_ready held high.
        a = 16'h0F0F; b = 16'h0101; in_valid = 1'b1; out_ready = 1'b1;
        acc_cnt = 0;
        last_acc = -1;
        for (int i = 0; i < 36; i++) begin
            if (in_ready) begin
                if (last_acc >= 0) check("b2b_gap", i - last_acc, NIBBLES + 2);
                last_acc = i;
                acc_cnt++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_count", acc_cnt, 6);
        repeat (10) @(negedge clk);
        out_ready = 1'b0;
        check("final_ready", {{W{1'b0}}, in_ready}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
